// File: rtl/cla_addsub_pipe_pkg.sv
// Shared types and constants for the pipelined CLA adder/subtractor.
// Optional feature macro: CLA_ADDSUB_SAT_EN (signed saturation on overflow).
package cla_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int GROUP_W = 4;

  // Bits handled by each pipeline stage.
  function automatic int seg_w(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/cla_addsub_pipe_if.sv
// Handshake/data bundle for cla_addsub_pipe.
// Optional feature macro: CLA_ADDSUB_SAT_EN adds the sat request bit.
interface cla_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             op;
  logic             carryin;
`ifdef CLA_ADDSUB_SAT_EN
  logic             sat;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             carryout;
  logic             overflow;
  logic             zero;

  // Producer/consumer side (drives requests, accepts results).
  modport master (
`ifdef CLA_ADDSUB_SAT_EN
    output sat,
`endif
    output in_valid, src1, src2, op, carryin, out_ready,
    input  in_ready, out_valid, res, carryout, overflow, zero
  );

  // Arithmetic block side.
  modport slave (
`ifdef CLA_ADDSUB_SAT_EN
    input  sat,
`endif
    input  in_valid, src1, src2, op, carryin, out_ready,
    output in_ready, out_valid, res, carryout, overflow, zero
  );
endinterface

// File: rtl/cla_addsub_pipe_seg.sv
// Combinational N-bit two-level carry-lookahead segment (4-bit groups).
// Optional feature macro: CLA_ADDSUB_SAT_EN (not used in this file).
module cla_seg
  import cla_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         c_msb,
  output logic         zero
);
  localparam int NG = N / GROUP_W;

  logic [N-1:0] p, g;
  logic [N-1:0] gp, gg;   // group propagate/generate, low NG bits used
  logic [NG:0]  gc;       // carry into each group
  logic [N:0]   c;        // carry into each bit

  // Flat sum-of-products carry into position j from terms lo..j-1: each
  // term is a single AND, so the lookahead has no ripple chain.
  function automatic logic la(input logic [N-1:0] gv, input logic [N-1:0] pv,
                              input logic ci, input int lo, input int j);
    logic r, pr;
    r  = 1'b0;
    pr = 1'b1;
    for (int i = j - 1; i >= lo; i--) begin
      r  = r | (pr & gv[i]);
      pr = pr & pv[i];
    end
    return r | (pr & ci);
  endfunction

  // Bit p/g, group P/G, group carries, then bit carries inside each group.
  always_comb begin
    p  = a ^ b;
    g  = a & b;
    gp = '0;
    gg = '0;
    gc = '0;
    c  = '0;
    for (int j = 0; j < NG; j++) begin
      gp[j] = &p[j*GROUP_W +: GROUP_W];
      gg[j] = la(g, p, 1'b0, j*GROUP_W, j*GROUP_W + GROUP_W);
    end
    for (int j = 0; j <= NG; j++)
      gc[j] = la(gg, gp, cin, 0, j);
    for (int j = 0; j < NG; j++)
      for (int i = 0; i < GROUP_W; i++)
        c[j*GROUP_W + i] = la(g, p, gc[j], j*GROUP_W, j*GROUP_W + i);
    c[N] = gc[NG];
  end

  assign sum   = p ^ c[N-1:0];
  assign cout  = c[N];
  assign c_msb = c[N-1];
  assign zero  = ~|sum;

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined CLA adder/subtractor: one WIDTH/STAGES segment per stage,
// valid/ready on both sides with full backpressure.
// Optional feature macro: CLA_ADDSUB_SAT_EN (sat input, signed clamp on overflow).
module cla_addsub_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input logic         clk,
  input logic         reset,
  cla_addsub_if.slave bus
);
  localparam int SEG = seg_w(WIDTH, STAGES);

  if (STAGES < 1 || (WIDTH % (GROUP_W * STAGES)) != 0) begin : g_param_chk
    $error("cla_addsub_pipe: WIDTH must be a multiple of GROUP_W*STAGES");
  end

  // a/b keep the operand bits still to be processed, r the finished result bits.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] r;
    logic             c;     // carry out of the last processed segment
    logic             cmsb;  // carry into the top bit of that segment
    logic             z;     // all processed segments are zero
`ifdef CLA_ADDSUB_SAT_EN
    logic             sat;
`endif
  } stg_t;

  stg_t                       src   [STAGES];
  stg_t                       stg_d [STAGES];
  stg_t                       stg_q [STAGES];
  stg_t                       last;
  logic [STAGES-1:0]          vld_pipe_d, vld_pipe_q, vld_in, adv;
  logic [STAGES-1:0][SEG-1:0] seg_sum;
  logic [STAGES-1:0]          seg_cout, seg_cmsb, seg_zero;
  logic                       acc, ovf;

  // Operand conditioning at accept; later stages consume the previous register.
  always_comb begin
    src[0]   = '0;
    src[0].a = bus.src1;
    src[0].b = (bus.op == OP_SUB) ? ~bus.src2 : bus.src2;
    src[0].c = (bus.op == OP_SUB) ? 1'b1 : bus.carryin;
    src[0].z = 1'b1;
`ifdef CLA_ADDSUB_SAT_EN
    src[0].sat = bus.sat;
`endif
    for (int k = 1; k < STAGES; k++)
      src[k] = stg_q[k-1];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    cla_seg #(.N(SEG)) u_seg (
      .a     (src[k].a[k*SEG +: SEG]),
      .b     (src[k].b[k*SEG +: SEG]),
      .cin   (src[k].c),
      .sum   (seg_sum[k]),
      .cout  (seg_cout[k]),
      .c_msb (seg_cmsb[k]),
      .zero  (seg_zero[k])
    );
  end

  // Advance chain from the output back: a stage moves when empty or drained.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = !vld_pipe_q[STAGES-1] || bus.out_ready;
    for (int k = STAGES - 2; k >= 0; k--)
      adv[k] = !vld_pipe_q[k] || adv[k+1];
  end

  assign bus.in_ready = adv[0];
  assign acc          = bus.in_valid && adv[0];

  // Next stage contents: load segment result on advance, otherwise hold.
  always_comb begin
    vld_in    = vld_pipe_q << 1;
    vld_in[0] = acc;
    for (int k = 0; k < STAGES; k++) begin
      vld_pipe_d[k] = adv[k] ? vld_in[k] : vld_pipe_q[k];
      stg_d[k]      = stg_q[k];
      if (adv[k]) begin
        stg_d[k]                 = src[k];
        stg_d[k].r[k*SEG +: SEG] = seg_sum[k];
        stg_d[k].c               = seg_cout[k];
        stg_d[k].cmsb            = seg_cmsb[k];
        stg_d[k].z               = src[k].z & seg_zero[k];
      end
    end
  end

  // Stage registers; reset drops every in-flight transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe_q <= '0;
      for (int k = 0; k < STAGES; k++) stg_q[k] <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      for (int k = 0; k < STAGES; k++) stg_q[k] <= stg_d[k];
    end
  end

  // Final flags from the last stage, with optional signed clamp.
  always_comb begin
    last          = stg_q[STAGES-1];
    ovf           = last.c ^ last.cmsb;
    bus.out_valid = vld_pipe_q[STAGES-1];
    bus.res       = last.r;
    bus.carryout  = last.c;
    bus.overflow  = ovf;
    bus.zero      = last.z;
`ifdef CLA_ADDSUB_SAT_EN
    if (last.sat && ovf) begin
      bus.res  = last.a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      bus.zero = 1'b0;
    end
`endif
  end

endmodule

// File: doc/cla_addsub_pipe.md
Name: cla_addsub_pipe

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor; the successor of the team's fixed 16-bit CLA adder.
- Operand width is split into STAGES equal segments, one per pipeline stage. Each segment is a 4-bit-group CLA fed by the registered carry from the previous stage.
- Valid/ready handshakes on both sides; full backpressure. Feeds the ALU result mux and the flag register.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of 4*STAGES.
- STAGES, 2, pipeline depth = latency in cycles; 1..WIDTH/4.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input transaction present
- in_ready  out  1  block accepts input this cycle
- src1  in  WIDTH  operand A
- src2  in  WIDTH  operand B
- op  in  1  0 = add, 1 = subtract
- carryin  in  1  carry-in for add; ignored for subtract
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- res  out  WIDTH  sum/difference
- carryout  out  1  carry out of bit WIDTH-1 (sub: 1 = no borrow)
- overflow  out  1  signed overflow
- zero  out  1  res == 0

Behaviour:
- Reset is synchronous and active-high; clk and reset are the only clock/reset. The reset cycle clears all stage valid bits and zeroes all outputs: out_valid=0, res=0, carryout=0, overflow=0, zero=0. in_ready=1 in the first cycle after reset. Reset mid-operation discards all in-flight transactions; no partial result is emitted.
- Accept: transfer when in_valid && in_ready. Output: transfer when out_valid && out_ready.
- Operand conditioning at accept:
  - add: B = src2, cin = carryin.
  - sub: B = ~src2, cin = 1.
- Stage k (0-based) computes bits [SEG*(k+1)-1 : SEG*k], where SEG = WIDTH/STAGES.
  - Inputs: the segment of A and B, plus the carry registered from stage k-1 (stage 0 uses cin).
  - Inside a segment: p = a^b, g = a&b; group P/G per 4 bits; second-level lookahead across groups. No ripple between groups.
- Pipeline registers carry the following forward:
  - the unprocessed upper operand bits
  - the completed lower result bits
  - segment carry
  - running zero flag (AND of segment-zero)
  - carry into the MSB (needed for overflow)
- Final flags:
  - carryout = carry out of the top segment.
  - overflow = c[WIDTH] ^ c[WIDTH-1].
  - zero = AND of all segment-zero bits.
- Latency: exactly STAGES cycles from accept to out_valid with out_ready held high. Throughput: one transaction per cycle.
- Flow control: stage k advances when it is empty or stage k+1 advances; the last stage advances on out_ready. in_ready = !valid[0] || advance[0], a combinational path from out_ready.
- Backpressure: while out_valid && !out_ready, res and all flags hold stable. No bubble is inserted on release.
- Accept and emit in the same cycle on a full pipe: allowed, no loss.
- Wrap-around: results are modulo 2^WIDTH. 0xFFFFFFFF + 1 gives 0 with carryout=1.

Optional Feature:
- Macro: CLA_ADDSUB_SAT_EN.
- When defined:
  - extra input port sat (1 bit), captured at accept and carried through the pipeline.
  - If sat=1 and overflow=1, res is clamped to the signed limit: 0x7FF..F if A's MSB=0, else 0x800..0.
  - When clamped, zero=0; overflow still reports 1.
- When undefined: no sat port; res is always the modular result.

Decomposition:
- Package cla_pkg:
  - OP_ADD=1'b0, OP_SUB=1'b1
  - GROUP_W=4
  - function for the segment width
  - elaboration-time check that WIDTH % (GROUP_W*STAGES)==0
- Sub-module cla_seg: combinational, parameter N (multiple of 4).
  - Inputs a, b, cin.
  - Outputs sum, cout, c_msb (carry into bit N-1), zero.
  - Two-level 4-bit-group lookahead.
  - Instantiated STAGES times by a generate loop.

Test Plan (WIDTH=32, STAGES=2 unless noted):
- Reset check: hold reset 2 cycles during in_valid=1 → out_valid=0, res=0, all flags 0; first accepted transaction appears 2 cycles after accept.
- Add with carry across the segment boundary: 0x0000FFFF + 0x00000001, cin=0 → res=0x00010000, carryout=0, overflow=0, zero=0.
- Subtract to zero: 0x12345678 - 0x12345678 → res=0, zero=1, carryout=1. Then 0x00000000 - 0x00000001 → res=0xFFFFFFFF, carryout=0.
- Signed overflow: 0x7FFFFFFF + 1 → res=0x80000000, overflow=1, carryout=0. With CLA_ADDSUB_SAT_EN and sat=1 → res=0x7FFFFFFF.
- Backpressure: stream 8 back-to-back adds; hold out_ready=0 for cycles 3–6 → in_ready drops once both stages are full, outputs stay stable, all 8 results emerge in order with no loss or duplication.
- Parameter sweep: WIDTH=16, STAGES=1 (latency 1) and WIDTH=64, STAGES=4 (latency 4) → 10k random add/sub vectors match a reference model, including carryin=1.
